// File: rtl/inst_rom_arbiter.sv
// Two-port instruction ROM arbiter: port A (fetch) and port B (debug/loader) share one ROM read port.
// Build option: define INST_ROM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; otherwise the arbiter is round-robin.
module inst_rom_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_valid,
  output logic        b_valid,
  output logic [31:0] a_data,
  output logic [31:0] b_data,
  output logic        a_err,
  output logic        b_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  // Any address bit at or above this position lies outside the ROM.
  localparam int unsigned   LO_BITS = ADDR_WIDTH + 2;
  localparam logic [32:0]   LIMIT   = 33'd1 << LO_BITS;
  localparam logic [31:0]   HI_MASK = ~(LIMIT[31:0] - 32'd1);

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr & HI_MASK) != 32'd0);
  endfunction

  logic        a_valid_q, a_valid_d;
  logic        b_valid_q, b_valid_d;
  logic        err_q, err_d;
  logic [31:0] a_data_q, a_data_d;
  logic [31:0] b_data_q, b_data_d;
  logic [31:0] rom_addr_q, rom_addr_d;

`ifdef INST_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      a_gnt = a_req;
      b_gnt = b_req & ~a_req;
    end
  end
`else
  // ptr state | meaning
  // PTR_A     | port A wins the next contended cycle
  // PTR_B     | port B wins the next contended cycle
  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e ptr_q, ptr_d;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    ptr_d = ptr_q;
    if (reset_n) begin
      if (a_req && (!b_req || ptr_q == PTR_A)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
    if (a_gnt) begin
      ptr_d = PTR_B;
    end else if (b_gnt) begin
      ptr_d = PTR_A;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // The ROM registers its address itself, so the granted address goes out combinationally.
  always_comb begin
    rom_addr_d = rom_addr_q;
    err_d      = 1'b0;
    if (a_gnt) begin
      rom_addr_d = a_addr;
      err_d      = addr_bad(a_addr);
    end else if (b_gnt) begin
      rom_addr_d = b_addr;
      err_d      = addr_bad(b_addr);
    end
    a_valid_d = a_gnt;
    b_valid_d = b_gnt;
  end

  assign rom_addr = rom_addr_d;

  always_comb begin
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    if (a_valid_q) begin
      a_data_d = err_q ? 32'd0 : rom_data;
    end
    if (b_valid_q) begin
      b_data_d = err_q ? 32'd0 : rom_data;
    end
  end

  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign a_err   = a_valid_q & err_q;
  assign b_err   = b_valid_q & err_q;
  assign a_data  = a_data_d;
  assign b_data  = b_data_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      a_data_q   <= 32'd0;
      b_data_q   <= 32'd0;
      rom_addr_q <= 32'd0;
    end else begin
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      err_q      <= err_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      rom_addr_q <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: vector table plus hand-written reset sequences.
module tb_inst_rom_arbiter;

`ifdef INST_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_gnt, b_gnt, a_valid, b_valid, a_err, b_err;
  logic [31:0] a_data, b_data, rom_addr;
  logic [31:0] rom_data = 32'd0;

  int tests  = 0;
  int errors = 0;

  inst_rom_arbiter #(.ADDR_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .b_req(b_req), .b_addr(b_addr),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_valid(a_valid), .b_valid(b_valid),
    .a_data(a_data), .b_data(b_data), .a_err(a_err), .b_err(b_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 2) return 32'h12345678;
    if (i == 5) return 32'hDEADBEEF;
    return {8'hC0, b, 8'h5A, b};
  endfunction

  // ROM with one-cycle registered read
  always @(posedge clock) rom_data <= word(int'(rom_addr[9:2]));

  typedef struct {
    logic        ar; logic [31:0] aa; logic br; logic [31:0] ba;
    logic        ag; logic bg; logic [31:0] ra;
    logic        av; logic ae; logic [31:0] ad;
    logic        bv; logic be; logic [31:0] bd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ar, input logic [31:0] aa, input logic br, input logic [31:0] ba,
                     input logic ag, input logic bg, input logic [31:0] ra,
                     input logic av, input logic ae, input logic [31:0] ad,
                     input logic bv, input logic be, input logic [31:0] bd);
    vec_t v;
    v.ar = ar; v.aa = aa; v.br = br; v.ba = ba; v.ag = ag; v.bg = bg; v.ra = ra;
    v.av = av; v.ae = ae; v.ad = ad; v.bv = bv; v.be = be; v.bd = bd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
    $fatal(1);
  end

  initial begin
    // vector table: inputs | gnts, rom_addr | A response | B response
    add(1, 32'h8, 0, 0,   1, 0, 32'h8,   0, 0, 0,            0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 32'h8,   1, 0, 32'h12345678, 0, 0, 0);
    add(0, 0, 1, 32'hC,   0, 1, 32'hC,   0, 0, 32'h12345678, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic ga;
      logic [31:0] ad_e, bd_e;
      logic av_e, bv_e;
      ga   = FIXED ? 1'b1 : (k % 2 == 0);
      av_e = (k > 0) && (FIXED || (k % 2 == 1));
      bv_e = (k == 0) || (!FIXED && (k % 2 == 0));
      ad_e = (k == 0) ? 32'h12345678 : word(4);
      bd_e = (FIXED || k < 2) ? word(3) : word(8);
      add(1, 32'h10, 1, 32'h20, ga, !ga, ga ? 32'h10 : 32'h20,
          av_e, 0, ad_e, bv_e, 0, bd_e);
    end
    add(0, 0, 1, 32'h20,  0, 1, 32'h20,  FIXED, 0, word(4), !FIXED, 0, FIXED ? word(3) : word(8));
    add(0, 0, 1, 32'h402, 0, 1, 32'h402, 0, 0, word(4),     1, 0, word(8));
    add(0, 0, 1, 32'h400, 0, 1, 32'h400, 0, 0, word(4),     1, 1, 0);
    add(0, 0, 0, 0,       0, 0, 32'h400, 0, 0, word(4),     1, 1, 0);
    add(0, 0, 0, 0,       0, 0, 32'h400, 0, 0, word(4),     0, 0, 0);
    add(1, 32'h14, 0, 0,  1, 0, 32'h14,  0, 0, word(4),     0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 32'h14,  1, 0, 32'hDEADBEEF, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0,     0, 0, 32'h14,  0, 0, 32'hDEADBEEF, 0, 0, 0);
    add(1, 32'h80000008, 0, 0, 1, 0, 32'h80000008, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 32'h80000008, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 32'h80000008, 0, 0, 0, 0, 0, 0);

    // reset with requests pending: nothing granted, everything cleared
    reset_n = 1'b0;
    a_req = 1'b1; a_addr = 32'h8; b_req = 1'b1; b_addr = 32'h20;
    @(negedge clock); @(negedge clock);
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    a_req = 1'b0; b_req = 1'b0;

    foreach (vecs[i]) begin
      string s;
      @(negedge clock);
      a_req = vecs[i].ar; a_addr = vecs[i].aa; b_req = vecs[i].br; b_addr = vecs[i].ba;
      #1;
      s = $sformatf("v%0d", i);
      chk({s, "_a_gnt"},    a_gnt,    vecs[i].ag);
      chk({s, "_b_gnt"},    b_gnt,    vecs[i].bg);
      chk({s, "_rom_addr"}, rom_addr, vecs[i].ra);
      chk({s, "_a_valid"},  a_valid,  vecs[i].av);
      chk({s, "_a_err"},    a_err,    vecs[i].ae);
      chk({s, "_a_data"},   a_data,   vecs[i].ad);
      chk({s, "_b_valid"},  b_valid,  vecs[i].bv);
      chk({s, "_b_err"},    b_err,    vecs[i].be);
      chk({s, "_b_data"},   b_data,   vecs[i].bd);
    end

    // grant in cycle N, then async reset in the middle of N+1
    @(negedge clock);
    a_req = 1'b1; a_addr = 32'h8; b_req = 1'b0;
    #1;
    chk("mid_gnt_a", a_gnt, 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h10; b_addr = 32'h20;
    #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_a_data", a_data, 0);
    chk("mid_rst_a_gnt", a_gnt, 0);
    chk("mid_rst_b_gnt", b_gnt, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_b_data", b_data, 0);
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_a_gnt", a_gnt, 1);
    chk("post_rst_b_gnt", b_gnt, 0);
    chk("post_rst_a_valid", a_valid, 0);
    chk("post_rst_rom_addr", rom_addr, 32'h10);
    @(negedge clock);
    #1;
    chk("post_rst2_a_valid", a_valid, 1);
    chk("post_rst2_a_data", a_data, word(4));
    chk("post_rst2_b_gnt", b_gnt, !FIXED);
    chk("post_rst2_a_gnt", a_gnt, FIXED);
    @(negedge clock);
    a_req = 1'b0; b_req = 1'b0;
    #1;
    chk("tail_b_valid", b_valid, !FIXED);
    chk("tail_gnt", {a_gnt, b_gnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
